ccr_flag_unit: RTL and testbench
================================

Name: ccr_flag_unit

Overview:
- Condition-code register for the pipelined processor; the consumer side of the ALU's carry/zero/neg outputs.
- Latches ALU flags per instruction class and services SETC/CLRC.
- Resolves conditional branches (JZ/JN/JC/JMP), clearing the tested flag when a conditional branch is taken.
- Saves flags on interrupt entry into a small LIFO and restores them on RTI.

Parameters:
- SAVE_DEPTH, 2, number of nested interrupt flag frames held (1..4).
- FLAG_W, 3, flag vector width; fixed order {neg, carry, zero} = bits [2:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_zero  in  1  zero flag from ALU (this cycle's EX result).
- alu_carry  in  1  carry flag from ALU.
- alu_neg  in  1  negative flag from ALU.
- alu_flag_we  in  FLAG_W  per-flag update enable from EX control; bit order matches flags.
- setc  in  1  force carry=1.
- clrc  in  1  force carry=0.
- br_valid  in  1  branch instruction in resolve stage.
- br_cond  in  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- int_save  in  1  push current flags (interrupt entry), one-cycle pulse.
- rti_restore  in  1  pop flags (RTI), one-cycle pulse.
- flags  out  FLAG_W  registered flag vector {neg, carry, zero}.
- br_taken  out  1  combinational branch decision, valid when br_valid.
- stack_empty  out  1  no saved frame.
- stack_full  out  1  SAVE_DEPTH frames held.
- save_err  out  1  sticky: push when full or pop when empty.

Behaviour:
- Reset (async, rst_n=0): flags=000, stack cleared, stack_empty=1, stack_full=0, save_err=0. br_taken=0 while br_valid=0.
- br_taken (combinational, zero latency):
  - br_valid & (cond==JMP | tested flag==1), where JZ tests zero, JN tests neg, JC tests carry.
  - The tested flag is the registered flags value; see Optional Feature for the bypass case.
- Next-state flag update, applied in priority order (later item overrides earlier, per bit):
  1. Hold current value.
  2. Taken conditional branch (not JMP) clears its tested flag.
  3. ALU write: bit i <= alu value where alu_flag_we[i]=1.
  4. setc / clrc act on carry only. setc&clrc together: carry unchanged, save_err not set (illegal encoding ignored).
  5. rti_restore with a non-empty stack: flags <= popped frame, overriding all of the above.
- int_save:
  - Pushes the current registered flags (pre-update value of this cycle); the flag update in the same cycle still proceeds.
  - Push when full: frame dropped, save_err=1.
- rti_restore when empty: flags follow the normal update, save_err=1.
- int_save & rti_restore in the same cycle: restore executes; the pushed value is the current registered flags; net depth is unchanged; the restored frame is the previous top.
- Status timing:
  - stack_full and stack_empty are registered; they update on the edge after the push/pop.
  - save_err clears only on reset.
- No handshakes: all inputs are single-cycle qualified; the unit never stalls.

Optional Feature:
- Macro CCR_BYPASS_EN.
- Defined: if br_valid and the alu_flag_we bit for the tested flag are both set in the same cycle, br_taken uses the live ALU flag instead of the registered one. This forwards flags from an ALU op immediately ahead of the branch.
- Defined, clear rule: the taken-branch clear still applies to the register, and the ALU write wins per the priority list.
- Undefined: br_taken uses registered flags only; the pipeline inserts one bubble between a flag-writing op and a dependent branch.

Decomposition:
- Package ccr_pkg holds:
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_N=2;
  - branch condition encodings COND_JZ/JN/JC/JMP;
  - the flag vector typedef.
- One sub-module, ccr_save_stack: SAVE_DEPTH x FLAG_W LIFO with push, pop, top, full, empty, and simultaneous push+pop = replace-top semantics.

Test Plan:
- Reset mid-run: flags=101 and one frame saved, assert rst_n=0 asynchronously -> flags=000, stack_empty=1, save_err=0 immediately, without waiting for a clock edge.
- ALU write: alu_zero=1, alu_neg=1, alu_carry=1, alu_flag_we=101 -> next cycle flags=101 (carry untouched); then setc -> flags=111.
- JZ taken with clear: flags=001, br_valid=1, br_cond=00 -> br_taken=1 same cycle; next cycle flags=000. Repeat the branch -> br_taken=0.
- Same-cycle conflict: flags=010, JC taken plus alu_flag_we=010 with alu_carry=1 -> flags stays 010 (ALU write wins). With CCR_BYPASS_EN and flags=000, alu_carry=1, we=010, JC -> br_taken=1.
- Nested interrupts, SAVE_DEPTH=2:
  - flags=001, push; flags=100, push; third push -> save_err=1, stack_full=1.
  - Pops -> flags=100 then 001.
  - Third pop -> save_err stays 1, stack_empty=1.
- Push+pop same cycle: stack holds [011], flags=110, assert both -> flags=011, stack top=110, depth=1.

Source files
------------

// File: rtl/ccr_pkg.sv
// ccr_pkg: flag indices, branch condition encodings and flag vector type for the condition-code unit
package ccr_pkg;
  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_N = 2'd2;
  localparam logic [1:0] COND_JZ  = 2'b00;
  localparam logic [1:0] COND_JN  = 2'b01;
  localparam logic [1:0] COND_JC  = 2'b10;
  localparam logic [1:0] COND_JMP = 2'b11;
  typedef logic [2:0] flags_t;
endpackage

// File: rtl/ccr_save_stack.sv
// ccr_save_stack: LIFO of saved flag frames; push+pop together replaces the top entry
module ccr_save_stack #(
  parameter int SAVE_DEPTH = 2,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         err_o
);
  localparam int CW = $clog2(SAVE_DEPTH + 1);
  logic [W-1:0] mem_q [SAVE_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, empty_q, do_push, do_pop;
  // A pop frees a slot, so a push alongside a successful pop never overflows
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);
  assign err_o   = (pop_i & empty_q) | (push_i & full_q & ~do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  assign top_o   = mem_q[0];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  // Entry 0 is always the top; pushes shift down, pops shift up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAVE_DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push && do_pop) begin
        mem_q[0] <= din_i;
      end else if (do_push) begin
        for (int i = 1; i < SAVE_DEPTH; i++) mem_q[i] <= mem_q[i-1];
        mem_q[0] <= din_i;
      end else if (do_pop) begin
        for (int i = 0; i < SAVE_DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
        mem_q[SAVE_DEPTH-1] <= '0;
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(SAVE_DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end
endmodule

// File: rtl/ccr_flag_unit.sv
// ccr_flag_unit: condition-code register with branch resolution and interrupt flag save/restore (macro CCR_BYPASS_EN forwards live ALU flags into branch decisions)
module ccr_flag_unit
  import ccr_pkg::*;
#(
  parameter int SAVE_DEPTH = 2,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_neg,
  input  logic [FLAG_W-1:0] alu_flag_we,
  input  logic              setc,
  input  logic              clrc,
  input  logic              br_valid,
  input  logic [1:0]        br_cond,
  input  logic              int_save,
  input  logic              rti_restore,
  output logic [FLAG_W-1:0] flags,
  output logic              br_taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              save_err
);
  flags_t flags_q, flags_d, alu_v, top;
  logic [1:0] idx;
  logic tested, stk_err, save_err_q;
  assign alu_v = {alu_neg, alu_carry, alu_zero};
  assign idx = (br_cond == COND_JZ) ? FLAG_Z : (br_cond == COND_JN) ? FLAG_N : FLAG_C;
`ifdef CCR_BYPASS_EN
  assign tested = alu_flag_we[idx] ? alu_v[idx] : flags_q[idx];
`else
  assign tested = flags_q[idx];
`endif
  assign br_taken = br_valid & ((br_cond == COND_JMP) | tested);
  assign flags    = flags_q;
  assign save_err = save_err_q;
  ccr_save_stack #(.SAVE_DEPTH(SAVE_DEPTH), .W(3)) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (int_save),
    .pop_i   (rti_restore),
    .din_i   (flags_q),
    .top_o   (top),
    .full_o  (stack_full),
    .empty_o (stack_empty),
    .err_o   (stk_err)
  );
  // Later updates override earlier ones: branch clear, ALU write, setc/clrc, then restore
  always_comb begin
    flags_d = flags_q;
    if (br_taken && br_cond != COND_JMP) flags_d[idx] = 1'b0;
    flags_d = (flags_d & ~alu_flag_we) | (alu_v & alu_flag_we);
    if (setc ^ clrc) flags_d[FLAG_C] = setc;
    if (rti_restore && !stack_empty) flags_d = top;
  end
  // Flag register and sticky save/restore error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      save_err_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      save_err_q <= save_err_q | stk_err;
    end
  end
endmodule

// File: tb/tb_ccr_flag_unit.sv
// tb_ccr_flag_unit: randomized and directed checks of ccr_flag_unit against a flag/queue reference model
module tb_ccr_flag_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic alu_zero = 0, alu_carry = 0, alu_neg = 0, setc = 0, clrc = 0;
  logic br_valid = 0, int_save = 0, rti_restore = 0;
  logic [2:0] alu_flag_we = 0;
  logic [1:0] br_cond = 0;
  logic [2:0] flags;
  logic br_taken, stack_empty, stack_full, save_err;
  int errs = 0, checks = 0;
  bit m_z, m_c, m_n, m_err;
  bit [2:0] q[$];

  ccr_flag_unit #(.SAVE_DEPTH(DEPTH), .FLAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_neg(alu_neg),
    .alu_flag_we(alu_flag_we), .setc(setc), .clrc(clrc), .br_valid(br_valid), .br_cond(br_cond),
    .int_save(int_save), .rti_restore(rti_restore), .flags(flags), .br_taken(br_taken),
    .stack_empty(stack_empty), .stack_full(stack_full), .save_err(save_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_z = 0; m_c = 0; m_n = 0; m_err = 0;
    q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".flags"}, {5'd0, flags}, {5'd0, m_n, m_c, m_z});
    check({tag, ".empty"}, {7'd0, stack_empty}, {7'd0, q.size() == 0});
    check({tag, ".full"}, {7'd0, stack_full}, {7'd0, q.size() == DEPTH});
    check({tag, ".err"}, {7'd0, save_err}, {7'd0, m_err});
  endtask

  // alu is {neg, carry, zero}; cond 0=JZ 1=JN 2=JC 3=JMP
  task automatic step(input string tag, input bit [2:0] we, input bit [2:0] alu, input bit sc, input bit cc,
                      input bit bv, input bit [1:0] cond, input bit sv, input bit rt);
    bit t, exp_taken, nz, nc, nn;
    bit [2:0] old, r;
    @(negedge clk);
    alu_flag_we = we; {alu_neg, alu_carry, alu_zero} = alu; setc = sc; clrc = cc;
    br_valid = bv; br_cond = cond; int_save = sv; rti_restore = rt;
    #1;
    case (cond)
      2'd0: t = m_z;
      2'd1: t = m_n;
      default: t = m_c;
    endcase
`ifdef CCR_BYPASS_EN
    if (cond == 2'd0 && we[0]) t = alu[0];
    if (cond == 2'd1 && we[2]) t = alu[2];
    if (cond == 2'd2 && we[1]) t = alu[1];
`endif
    exp_taken = bv && (cond == 2'd3 || t);
    check({tag, ".br_taken"}, {7'd0, br_taken}, {7'd0, exp_taken});
    nz = m_z; nc = m_c; nn = m_n;
    if (exp_taken && cond == 2'd0) nz = 0;
    if (exp_taken && cond == 2'd1) nn = 0;
    if (exp_taken && cond == 2'd2) nc = 0;
    if (we[0]) nz = alu[0];
    if (we[1]) nc = alu[1];
    if (we[2]) nn = alu[2];
    if (sc && !cc) nc = 1;
    if (cc && !sc) nc = 0;
    old = {m_n, m_c, m_z};
    if (rt) begin
      if (q.size() > 0) begin
        r = q.pop_back();
        {nn, nc, nz} = r;
      end else m_err = 1;
    end
    if (sv) begin
      if (q.size() < DEPTH) q.push_back(old);
      else m_err = 1;
    end
    @(posedge clk);
    #1;
    m_z = nz; m_c = nc; m_n = nn;
    check_state(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_state("reset");
    check("reset.br_taken", {7'd0, br_taken}, 8'd0);
    @(negedge clk) rst_n = 1;
    step("alu101", 3'b101, 3'b111, 0, 0, 0, 0, 0, 0);
    step("setc", 3'b000, 3'b000, 1, 0, 0, 0, 0, 0);
    step("both_sc", 3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    step("clrc", 3'b000, 3'b000, 0, 1, 0, 0, 0, 0);
    step("set001", 3'b111, 3'b001, 0, 0, 0, 0, 0, 0);
    step("jz_taken", 3'b000, 3'b000, 0, 0, 1, 2'd0, 0, 0);
    step("jz_again", 3'b000, 3'b000, 0, 0, 1, 2'd0, 0, 0);
    step("set010", 3'b111, 3'b010, 0, 0, 0, 0, 0, 0);
    step("jc_alu_wins", 3'b010, 3'b010, 0, 0, 1, 2'd2, 0, 0);
    step("set000", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0);
    step("jc_fwd", 3'b010, 3'b010, 0, 0, 1, 2'd2, 0, 0);
    step("jmp", 3'b000, 3'b000, 0, 0, 1, 2'd3, 0, 0);
    step("n001", 3'b111, 3'b001, 0, 0, 0, 0, 1, 0);
    step("n100", 3'b111, 3'b100, 0, 0, 0, 0, 1, 0);
    step("push3", 3'b000, 3'b000, 0, 0, 0, 0, 1, 0);
    step("pop1", 3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    step("pop2", 3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    step("pop3", 3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    step("s011", 3'b111, 3'b011, 0, 0, 0, 0, 1, 0);
    step("s110", 3'b111, 3'b110, 0, 0, 0, 0, 0, 0);
    step("pushpop", 3'b000, 3'b000, 0, 0, 0, 0, 1, 1);
    step("poptop", 3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    // Asynchronous reset mid-run, away from any clock edge
    step("pre_rst", 3'b111, 3'b101, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    int_save = 0; alu_flag_we = 0; br_valid = 0; setc = 0; clrc = 0; rti_restore = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 600; i++)
      step("rand", 3'($urandom), 3'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
